// File: rtl/hdmi_clock_supervisor_pkg.sv
// hdmi_clock_supervisor_pkg: FSM state encodings, 720p clock constants and the window range check.
package hdmi_clock_supervisor_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    DIV_SETTLE = 3'd1,
    MEASURE    = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_t;
  localparam int REF_HZ  = 27_000_000;
  localparam int PIX_HZ  = 74_250_000;
  localparam int TOG_DIV = 16;
  function automatic logic in_range(input logic [15:0] m, input int exp_e, input int tol);
    logic signed [16:0] d;
    d = $signed({1'b0, m}) - $signed(17'(exp_e));
    return (d <= $signed(17'(tol))) && (d >= -$signed(17'(tol)));
  endfunction
endpackage

// File: rtl/hdmi_clock_supervisor_sync_2ff.sv
// sync_2ff: parameterised-width two-flop synchroniser with asynchronous active-high reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  assign q = s2_q;
endmodule

// File: rtl/hdmi_clock_supervisor.sv
// hdmi_clock_supervisor: sequences CLKDIV reset from PLL lock and gates the pixel reset on a measured pixel clock.
module hdmi_clock_supervisor
  import hdmi_clock_supervisor_pkg::*;
#(
  parameter int LOCK_STABLE   = 2700,
  parameter int SETTLE_CYCLES = 270,
  parameter int GATE_CYCLES   = 27000,
  parameter int EXPECT_EDGES  = 4641,
  parameter int TOL_EDGES     = 16,
  parameter int MISS_LIMIT    = 3,
  parameter int FAULT_HOLD    = 27000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_lock,
  input  logic        pix_div_tog,
  output logic        clkdiv_resetn,
  output logic        pix_rst,
  output logic        clk_ok,
  output logic [15:0] meas_count,
  output logic        meas_valid,
  output logic [7:0]  fault_cnt
);
  state_t      state_q, state_d;
  logic        lock_sync, tog_s2, tog_d3_q, tog_edge, measuring, last, inr;
  logic [15:0] tmr_q, tmr_d, win_q, win_d, cnt_q, cnt_d, cnt_inc, meas_count_q, meas_count_d;
  logic [7:0]  miss_q, miss_d, fault_cnt_q, fault_cnt_d;
  logic        meas_valid_q, meas_valid_d, clkdiv_resetn_q, clkdiv_resetn_d;
  logic        pix_rst_q, pix_rst_d, clk_ok_q, clk_ok_d;

  sync_2ff #(.W(1)) u_lock_sync (.clk(clk), .rst(rst), .d(pll_lock),    .q(lock_sync));
  sync_2ff #(.W(1)) u_tog_sync  (.clk(clk), .rst(rst), .d(pix_div_tog), .q(tog_s2));

  // Edge counter and window; the last-cycle edge lands in meas_count, not in the next window.
  always_comb begin
    tog_edge     = tog_s2 ^ tog_d3_q;
    measuring    = (state_q == MEASURE) || (state_q == RUN);
    last         = measuring && (win_q == 16'(GATE_CYCLES - 1));
    cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + {15'd0, tog_edge};
    inr          = in_range(cnt_inc, EXPECT_EDGES, TOL_EDGES);
    win_d        = (measuring && !last) ? win_q + 16'd1 : 16'd0;
    cnt_d        = (measuring && !last) ? cnt_inc : 16'd0;
    meas_count_d = last ? cnt_inc : meas_count_q;
    meas_valid_d = last;
    miss_d       = (state_q == RUN) ? (last ? (inr ? 8'd0 : miss_q + 8'd1) : miss_q) : 8'd0;
  end

  // Lock loss outranks window-end evaluation; FAULT ignores lock until the hold expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK:  if (lock_sync && tmr_q == 16'(LOCK_STABLE - 1)) state_d = DIV_SETTLE;
      DIV_SETTLE: if (!lock_sync) state_d = WAIT_LOCK;
                  else if (tmr_q == 16'(SETTLE_CYCLES - 1)) state_d = MEASURE;
      MEASURE:    if (!lock_sync) state_d = WAIT_LOCK;
                  else if (last && inr) state_d = RUN;
      RUN:        if (!lock_sync) state_d = WAIT_LOCK;
                  else if (last && !inr && (miss_q + 8'd1 == 8'(MISS_LIMIT))) state_d = FAULT;
      FAULT:      if (tmr_q == 16'(FAULT_HOLD - 1)) state_d = WAIT_LOCK;
      default:    state_d = WAIT_LOCK;
    endcase
    tmr_d = (state_d != state_q || measuring || (state_q == WAIT_LOCK && !lock_sync)) ? 16'd0 : tmr_q + 16'd1;
    clkdiv_resetn_d = (state_q == DIV_SETTLE) || measuring;
    pix_rst_d       = state_q != RUN;
    clk_ok_d        = state_q == RUN;
    fault_cnt_d     = (state_q == FAULT && tmr_q == 16'd0 && fault_cnt_q != 8'hFF) ? fault_cnt_q + 8'd1 : fault_cnt_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q         <= WAIT_LOCK;
      tog_d3_q        <= 1'b0;
      tmr_q           <= '0;
      win_q           <= '0;
      cnt_q           <= '0;
      miss_q          <= '0;
      meas_count_q    <= '0;
      meas_valid_q    <= 1'b0;
      fault_cnt_q     <= '0;
      clkdiv_resetn_q <= 1'b0;
      pix_rst_q       <= 1'b1;
      clk_ok_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      tog_d3_q        <= tog_s2;
      tmr_q           <= tmr_d;
      win_q           <= win_d;
      cnt_q           <= cnt_d;
      miss_q          <= miss_d;
      meas_count_q    <= meas_count_d;
      meas_valid_q    <= meas_valid_d;
      fault_cnt_q     <= fault_cnt_d;
      clkdiv_resetn_q <= clkdiv_resetn_d;
      pix_rst_q       <= pix_rst_d;
      clk_ok_q        <= clk_ok_d;
    end

  assign clkdiv_resetn = clkdiv_resetn_q;
  assign pix_rst       = pix_rst_q;
  assign clk_ok        = clk_ok_q;
  assign meas_count    = meas_count_q;
  assign meas_valid    = meas_valid_q;
  assign fault_cnt     = fault_cnt_q;
endmodule

// File: tb/tb_hdmi_clock_supervisor.sv
// tb_hdmi_clock_supervisor: directed windows with a meas_count scoreboard and direct FSM output checks.
module tb_hdmi_clock_supervisor;
  logic        clk = 1'b0, rst = 1'b1, pll_lock = 1'b1, pix_div_tog = 1'b0;
  logic        clkdiv_resetn, pix_rst, clk_ok, meas_valid;
  logic [15:0] meas_count;
  logic [7:0]  fault_cnt;
  int checks = 0, errors = 0;
  int exp_q[$];
  int rise;

  always #5 clk = ~clk;

  hdmi_clock_supervisor #(
    .LOCK_STABLE(8), .SETTLE_CYCLES(4), .GATE_CYCLES(100), .EXPECT_EDGES(20),
    .TOL_EDGES(2), .MISS_LIMIT(3), .FAULT_HOLD(10)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .pix_div_tog(pix_div_tog),
    .clkdiv_resetn(clkdiv_resetn), .pix_rst(pix_rst), .clk_ok(clk_ok),
    .meas_count(meas_count), .meas_valid(meas_valid), .fault_cnt(fault_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL meas_unexpected actual=%0d expected=none", meas_count);
      end else check("meas_count", meas_count, exp_q.pop_front());
    end

  // Called at the start of cycle 0 of a bring-up; returns the cycle where clkdiv_resetn first reads 1.
  task automatic bring_up(input int glitch_at, output int r);
    r = -1;
    for (int k = 1; k <= 60 && r < 0; k++) begin
      @(posedge clk); #1;
      if (k == glitch_at) pll_lock = 1'b0;
      if (k == glitch_at + 1) pll_lock = 1'b1;
      if (clkdiv_resetn) r = k;
    end
  endtask

  // One 100-cycle window aligned to the DUT window; ok is the clk_ok expected from the previous window's result.
  task automatic window(input int n, input bit ok, input bit drop);
    exp_q.push_back(n);
    for (int i = 0; i < 100; i++) begin
      if (i >= 10 && i < 10 + 3 * n && (i - 10) % 3 == 0) pix_div_tog = ~pix_div_tog;
      if (i == 2) begin
        check("clk_ok", clk_ok, ok);
        check("pix_rst", pix_rst, !ok);
        check("clkdiv_resetn", clkdiv_resetn, 1);
      end
      if (drop && i == 97) pll_lock = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic fault_and_recover(input int fc);
    @(posedge clk); #1;
    check("fault_clkdiv", clkdiv_resetn, 0);
    check("fault_pix_rst", pix_rst, 1);
    check("fault_clk_ok", clk_ok, 0);
    check("fault_cnt", fault_cnt, fc);
    bring_up(1, rise);
    check("fault_to_div", rise, 18);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (20) begin @(posedge clk); #1; pix_div_tog = ~pix_div_tog; end
    check("rst_clkdiv", clkdiv_resetn, 0);
    check("rst_pix_rst", pix_rst, 1);
    check("rst_clk_ok", clk_ok, 0);
    check("rst_meas_count", meas_count, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_fault_cnt", fault_cnt, 0);
    rst = 1'b0;
    bring_up(0, rise);
    check("lock_to_div", rise, 11);
    #3 rst = 1'b1;
    #1 check("async_rst_clkdiv", clkdiv_resetn, 0);
    check("async_rst_pix_rst", pix_rst, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bring_up(5, rise);
    check("glitch_to_div", rise, 17);
    repeat (3) begin @(posedge clk); #1; end
    window(14, 0, 0);
    window(20, 0, 0);
    window(14, 1, 0);
    window(20, 1, 0);
    window(14, 1, 0);
    window(14, 1, 0);
    window(18, 1, 0);
    window(14, 1, 0);
    window(14, 1, 0);
    window(22, 1, 0);
    window(17, 1, 0);
    window(23, 1, 0);
    window(14, 1, 0);
    fault_and_recover(1);
    window(20, 0, 0);
    window(14, 1, 0);
    window(14, 1, 0);
    window(14, 1, 0);
    fault_and_recover(2);
    window(20, 0, 0);
    window(20, 1, 1);
    @(posedge clk); #1;
    check("drop_clk_ok", clk_ok, 0);
    check("drop_pix_rst", pix_rst, 1);
    check("drop_clkdiv", clkdiv_resetn, 0);
    check("drop_fault_cnt", fault_cnt, 2);
    repeat (20) begin @(posedge clk); #1; end
    check("drop_hold_clk_ok", clk_ok, 0);
    check("drop_hold_fault_cnt", fault_cnt, 2);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
